// File: rtl/systolic_grid.sv
`default_nettype none
// ============================================================================
// Module   : systolic_grid
// Purpose  : ROWS x COLS output-stationary systolic multiplier with skewed
//            operand feed and row-by-row result drain.
//            Optional build macro SYSTOLIC_GRID_SAT_EN: saturate output lanes.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_grid #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int DW    = 16,
    parameter int SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           k_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ROWS*DW-1:0]   a_data,
    input  logic [COLS*DW-1:0]   b_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COLS*DW-1:0]   out_data,
    output logic [COLS-1:0]      out_sat,
    output logic [7:0]           out_row,
    output logic                 busy,
    output logic                 done
);
    localparam int AW = 2*DW + 8;
    localparam int FW = (ROWS + COLS > 1) ? $clog2(ROWS + COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_feed  = 2'd1;
    localparam logic [1:0] c_st_flush = 2'd2;
    localparam logic [1:0] c_st_drain = 2'd3;

    localparam logic [FW-1:0] c_flush_last = FW'(ROWS + COLS - 1);
    localparam logic [7:0]    c_row_last   = 8'(ROWS - 1);

    localparam logic signed [AW-1:0] c_sat_max = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] c_sat_min = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic [1:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    klen_q, klen_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [7:0]    row_q, row_d;
    logic          done_q, done_d;

    logic w_clr;
    logic w_beat;
    logic w_beat_last;
    logic w_drain;
    logic w_drain_last;

    assign w_clr        = (state_q == c_st_idle) && start;
    assign w_beat       = (state_q == c_st_feed) && in_valid;
    assign w_beat_last  = w_beat && (({1'b0, cnt_q} + 9'd1) == {1'b0, klen_q});
    assign w_drain      = (state_q == c_st_drain);
    assign w_drain_last = w_drain && out_ready && (row_q == c_row_last);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle:  if (start) state_d = (k_len != 8'd0) ? c_st_feed : c_st_drain;
            c_st_feed:  if (w_beat_last) state_d = c_st_flush;
            c_st_flush: if (fcnt_q == c_flush_last) state_d = c_st_drain;
            c_st_drain: if (w_drain_last) state_d = c_st_idle;
            default:    state_d = c_st_idle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == c_st_feed);
        out_valid = w_drain;
        busy      = (state_q != c_st_idle);
        done      = done_q;
        out_row   = row_q;
    end

    // ------------------------------------------------------------ counters
    always_comb begin
        cnt_d  = cnt_q;
        klen_d = klen_q;
        row_d  = row_q;
        done_d = w_drain_last;
        fcnt_d = (state_q == c_st_flush) ? fcnt_q + FW'(1) : '0;
        if (w_clr) begin
            cnt_d  = '0;
            klen_d = k_len;
        end
        if (w_beat) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (w_drain && out_ready) begin
            row_d = w_drain_last ? 8'd0 : row_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            klen_q <= '0;
            fcnt_q <= '0;
            row_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            klen_q <= klen_d;
            fcnt_q <= fcnt_d;
            row_q  <= row_d;
            done_q <= done_d;
        end
    end

    // ------------------------------------------------------ input skewing
    logic [DW-1:0]   w_a_sk [ROWS];
    logic [ROWS-1:0] w_av_sk;
    logic [DW-1:0]   w_b_sk [COLS];
    logic [COLS-1:0] w_bv_sk;

    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        if (i == 0) begin : g_direct
            assign w_a_sk[i]  = a_data[i*DW +: DW];
            assign w_av_sk[i] = w_beat;
        end else begin : g_delay
            logic [DW-1:0] sk_q [i];
            logic [DW-1:0] sk_d [i];
            logic [i-1:0]  skv_q, skv_d;
            always_comb begin
                sk_d[0]  = a_data[i*DW +: DW];
                skv_d[0] = w_beat;
                for (int n = 1; n < i; n++) begin
                    sk_d[n]  = sk_q[n-1];
                    skv_d[n] = skv_q[n-1];
                end
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int n = 0; n < i; n++) sk_q[n] <= '0;
                    skv_q <= '0;
                end else begin
                    sk_q  <= sk_d;
                    skv_q <= skv_d;
                end
            end
            assign w_a_sk[i]  = sk_q[i-1];
            assign w_av_sk[i] = skv_q[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_b_skew
        if (j == 0) begin : g_direct
            assign w_b_sk[j]  = b_data[j*DW +: DW];
            assign w_bv_sk[j] = w_beat;
        end else begin : g_delay
            logic [DW-1:0] sk_q [j];
            logic [DW-1:0] sk_d [j];
            logic [j-1:0]  skv_q, skv_d;
            always_comb begin
                sk_d[0]  = b_data[j*DW +: DW];
                skv_d[0] = w_beat;
                for (int n = 1; n < j; n++) begin
                    sk_d[n]  = sk_q[n-1];
                    skv_d[n] = skv_q[n-1];
                end
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int n = 0; n < j; n++) sk_q[n] <= '0;
                    skv_q <= '0;
                end else begin
                    sk_q  <= sk_d;
                    skv_q <= skv_d;
                end
            end
            assign w_b_sk[j]  = sk_q[j-1];
            assign w_bv_sk[j] = skv_q[j-1];
        end
    end

    // ------------------------------------------------------------ PE grid
    logic [DW-1:0]        w_a_pe  [ROWS][COLS];
    logic [DW-1:0]        w_b_pe  [ROWS][COLS];
    logic                 w_av_pe [ROWS][COLS];
    logic                 w_bv_pe [ROWS][COLS];
    logic signed [AW-1:0] w_acc   [ROWS][COLS];

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic [DW-1:0]          w_a_in, w_b_in;
            logic                   w_av_in, w_bv_in;
            logic signed [2*DW-1:0] w_prod;
            logic [DW-1:0]          a_q, a_d, b_q, b_d;
            logic                   av_q, av_d, bv_q, bv_d;
            logic signed [AW-1:0]   acc_q, acc_d;

            if (j == 0) begin : g_a_edge
                assign w_a_in  = w_a_sk[i];
                assign w_av_in = w_av_sk[i];
            end else begin : g_a_nbr
                assign w_a_in  = w_a_pe[i][j-1];
                assign w_av_in = w_av_pe[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign w_b_in  = w_b_sk[j];
                assign w_bv_in = w_bv_sk[j];
            end else begin : g_b_nbr
                assign w_b_in  = w_b_pe[i-1][j];
                assign w_bv_in = w_bv_pe[i-1][j];
            end

            assign w_prod = $signed(w_a_in) * $signed(w_b_in);

            always_comb begin
                a_d   = w_a_in;
                b_d   = w_b_in;
                av_d  = w_av_in;
                bv_d  = w_bv_in;
                acc_d = acc_q;
                if (w_clr) begin
                    acc_d = '0;
                end else if (w_av_in && w_bv_in) begin
                    acc_d = acc_q + AW'(w_prod);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    av_q  <= 1'b0;
                    bv_q  <= 1'b0;
                    acc_q <= '0;
                end else begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    av_q  <= av_d;
                    bv_q  <= bv_d;
                    acc_q <= acc_d;
                end
            end

            assign w_a_pe[i][j]  = a_q;
            assign w_b_pe[i][j]  = b_q;
            assign w_av_pe[i][j] = av_q;
            assign w_bv_pe[i][j] = bv_q;
            assign w_acc[i][j]   = acc_q;
        end
    end

    // ------------------------------------------------------- output lanes
    for (genvar j = 0; j < COLS; j++) begin : g_lane
        logic signed [AW-1:0] w_shift;
        logic [DW-1:0]        w_val;
        logic                 w_sat;

        assign w_shift = w_acc[row_q[RW-1:0]][j] >>> SHIFT;
`ifdef SYSTOLIC_GRID_SAT_EN
        always_comb begin
            w_val = w_shift[DW-1:0];
            w_sat = 1'b0;
            if (w_shift > c_sat_max) begin
                w_val = c_sat_max[DW-1:0];
                w_sat = 1'b1;
            end else if (w_shift < c_sat_min) begin
                w_val = c_sat_min[DW-1:0];
                w_sat = 1'b1;
            end
        end
`else
        logic w_unused_hi;
        assign w_val       = w_shift[DW-1:0];
        assign w_sat       = 1'b0;
        assign w_unused_hi = ^w_shift[AW-1:DW];
`endif
        // Lanes read zero outside DRAIN so idle/reset outputs are clean.
        assign out_data[j*DW +: DW] = w_drain ? w_val : '0;
        assign out_sat[j]           = w_drain & w_sat;
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_grid.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_grid
// Purpose  : Self-checking bench for systolic_grid against a matrix-product
//            reference model (directed jobs followed by randomized jobs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_grid;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DW    = 16;
    localparam int SHIFT = 0;
    localparam int MAXK  = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [7:0]          k_len;
    logic                in_valid;
    logic                in_ready;
    logic [ROWS*DW-1:0]  a_data;
    logic [COLS*DW-1:0]  b_data;
    logic                out_valid;
    logic                out_ready;
    logic [COLS*DW-1:0]  out_data;
    logic [COLS-1:0]     out_sat;
    logic [7:0]          out_row;
    logic                busy;
    logic                done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    shortint mat_a [ROWS][MAXK];
    shortint mat_b [MAXK][COLS];

    systolic_grid #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_data    (a_data),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_row   (out_row),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // C(r,j) = sum_k A(r,k)*B(k,j), shifted, then wrapped or clamped to DW bits
    function automatic void model_lane(input int r, input int j, input int k,
                                       output logic [DW-1:0] val, output logic sat);
        longint s;
        s = 0;
        for (int t = 0; t < k; t++) s += longint'(mat_a[r][t]) * longint'(mat_b[t][j]);
        s   = s >>> SHIFT;
        val = s[DW-1:0];
        sat = 1'b0;
`ifdef SYSTOLIC_GRID_SAT_EN
        if (s > 32767) begin
            val = 16'h7FFF;
            sat = 1'b1;
        end else if (s < -32768) begin
            val = 16'h8000;
            sat = 1'b1;
        end
`endif
    endfunction

    task automatic fill_identity();
        for (int r = 0; r < ROWS; r++)
            for (int t = 0; t < MAXK; t++) mat_a[r][t] = (r == t) ? 16'sd1 : 16'sd0;
        for (int t = 0; t < MAXK; t++)
            for (int j = 0; j < COLS; j++) mat_b[t][j] = shortint'(t*COLS + j + 1);
    endtask

    task automatic fill_const(input shortint v);
        for (int r = 0; r < ROWS; r++)
            for (int t = 0; t < MAXK; t++) mat_a[r][t] = v;
        for (int t = 0; t < MAXK; t++)
            for (int j = 0; j < COLS; j++) mat_b[t][j] = v;
    endtask

    task automatic fill_random();
        for (int r = 0; r < ROWS; r++)
            for (int t = 0; t < MAXK; t++) mat_a[r][t] = shortint'($urandom);
        for (int t = 0; t < MAXK; t++)
            for (int j = 0; j < COLS; j++) mat_b[t][j] = shortint'($urandom);
    endtask

    task automatic drive_beat(input int t);
        for (int r = 0; r < ROWS; r++) a_data[r*DW +: DW] = mat_a[r][t];
        for (int j = 0; j < COLS; j++) b_data[j*DW +: DW] = mat_b[t][j];
    endtask

    // One complete job: start, feed k beats, wait out FLUSH, drain every row.
    task automatic run_job(input int k, input bit bubbles, input int bp_row,
                           input bit poke_start, input string name);
        int b, cyc, r, stall, quiet;
        logic [COLS*DW-1:0] exp_row;
        logic [COLS-1:0]    exp_sat;
        logic [DW-1:0]      v;
        logic               s;

        @(negedge clk);
        start = 1'b1;
        k_len = 8'(k);
        @(negedge clk);
        start = 1'b0;
        check({name, " busy_after_start"}, busy, 1'b1);
        check({name, " in_ready_first"}, in_ready, (k > 0));

        b   = 0;
        cyc = 0;
        while (b < k && cyc < 1000) begin
            in_valid = !(bubbles && (cyc % 2 == 1));
            if (in_valid) begin
                drive_beat(b);
            end else begin
                a_data = {$urandom, $urandom};
                b_data = {$urandom, $urandom};
            end
            if (in_valid && in_ready) b++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check({name, " beats_accepted"}, b, k);
        check({name, " in_ready_after_feed"}, in_ready, 1'b0);

        quiet = 0;
        while (!out_valid && quiet < 100) begin
            @(negedge clk);
            quiet++;
        end
        if (k > 0) check({name, " flush_cycles"}, quiet, ROWS + COLS);
        else       check({name, " drain_immediate"}, quiet, 0);

        r     = 0;
        stall = 0;
        cyc   = 0;
        while (r < ROWS && cyc < 200) begin
            for (int j = 0; j < COLS; j++) begin
                model_lane(r, j, k, v, s);
                exp_row[j*DW +: DW] = v;
                exp_sat[j]          = s;
            end
            check({name, " out_valid"}, out_valid, 1'b1);
            check({name, " out_row"}, out_row, r);
            check({name, " out_data"}, out_data, exp_row);
            check({name, " out_sat"}, out_sat, exp_sat);
            out_ready = 1'b1;
            if (r == bp_row && stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end
            start = poke_start && (r == 2);
            if (out_ready) r++;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        start     = 1'b0;
        check({name, " rows_drained"}, r, ROWS);
        check({name, " done_pulse"}, done, 1'b1);
        check({name, " busy_at_done"}, busy, 1'b0);
        check({name, " out_valid_idle"}, out_valid, 1'b0);
        @(negedge clk);
        check({name, " done_single"}, done, 1'b0);
        check({name, " busy_idle"}, busy, 1'b0);
    endtask

    initial begin
        bit saw_done;
        rst       = 1'b1;
        start     = 1'b0;
        k_len     = 8'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_data    = '0;
        b_data    = '0;
        repeat (3) @(negedge clk);
        check("reset in_ready", in_ready, 1'b0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_data", out_data, 64'h0);
        check("reset out_sat", out_sat, 4'h0);
        check("reset out_row", out_row, 8'h0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        rst = 1'b0;

        fill_identity();
        run_job(4, 1'b0, -1, 1'b0, "identity");

        fill_const(16'sh7FFF);
        run_job(4, 1'b0, -1, 1'b0, "saturate");

        fill_identity();
        run_job(4, 1'b1, -1, 1'b0, "bubbles");
        run_job(4, 1'b0, 1, 1'b0, "backpressure");
        run_job(0, 1'b0, -1, 1'b1, "k_zero");

        // Abort a job mid-FEED after two beats.
        @(negedge clk);
        start = 1'b1;
        k_len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 2; t++) begin
            in_valid = 1'b1;
            drive_beat(t);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", busy, 1'b0);
        check("abort in_ready", in_ready, 1'b0);
        check("abort done", done, 1'b0);
        check("abort out_valid", out_valid, 1'b0);
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        check("abort no_done", saw_done, 1'b0);

        fill_identity();
        run_job(4, 1'b0, -1, 1'b0, "post_reset");

        for (int n = 0; n < 6; n++) begin
            fill_random();
            run_job($urandom_range(1, 8), 1'($urandom_range(0, 1)),
                    $urandom_range(0, ROWS-1), 1'b0, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
